// File: rtl/rs_dsp_mac_accum_pkg.sv
// Shared widths, FSM state type and the saturating adder used by the
// DSP38 product accumulator.
package rs_dsp_pkg;

    localparam int A_W     = 20;   // multiplier A port
    localparam int B_W     = 18;   // multiplier B port
    localparam int Z_W     = 38;   // multiplier product
    localparam int ACC_MAX = 64;   // widest accumulator sat_add can serve

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [ACC_MAX-1:0] sum;
        logic               overflow;
    } sat_res_t;

    // Saturating add on ACC_MAX-bit operands. Callers left-align narrower
    // accumulators so the top bit is the real sign/carry bit; the clamp
    // values then land correctly in the upper bits after realignment.
    function automatic sat_res_t sat_add(
        input logic [ACC_MAX-1:0] acc,
        input logic [ACC_MAX-1:0] addend,
        input logic               signed_mode
    );
        logic [ACC_MAX:0] raw;
        sat_res_t         res;
        raw          = {1'b0, acc} + {1'b0, addend};
        // NOTE: every result field gets a default before the branches, so
        // no path leaves it unassigned (which would infer a latch in comb logic).
        res.sum      = raw[ACC_MAX-1:0];
        res.overflow = 1'b0;
        if (signed_mode) begin
            // Overflow only when both operands share a sign the sum lacks.
            if ((acc[ACC_MAX-1] == addend[ACC_MAX-1]) &&
                (raw[ACC_MAX-1] != acc[ACC_MAX-1])) begin
                res.overflow = 1'b1;
                res.sum      = {acc[ACC_MAX-1], {(ACC_MAX-1){~acc[ACC_MAX-1]}}};
            end
        end else if (raw[ACC_MAX]) begin
            res.overflow = 1'b1;
            res.sum      = '1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_dsp_mac_accum_if.sv
// Operand-in / result-out handshake bundle of the product accumulator.
interface rs_dsp_mac_accum_if #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 8
);
    import rs_dsp_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             in_last;
    logic             in_unsigned_a;
    logic             in_unsigned_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, in_a, in_b, in_last, in_unsigned_a, in_unsigned_b,
        output out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_a, in_b, in_last, in_unsigned_a, in_unsigned_b,
        input  out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );

endinterface

// File: rtl/rs_dsp_mac_accum_valid_pipe.sv
// {valid, last} flag shift register that travels alongside the external
// multiplier, so the accumulator knows when mult_z carries a live product.
module rs_dsp_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  logic push_last,
    output logic tail_valid,
    output logic tail_last
);

    logic [DEPTH-1:0] valid_sr;
    logic [DEPTH-1:0] last_sr;

    // Shift flags one stage per clock; clearing them on reset discards any
    // product still inside the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_sr <= '0;
            last_sr  <= '0;
        end else begin
            // NOTE: non-blocking assignments make each stage take its
            // predecessor's pre-edge value, independent of statement order.
            valid_sr[0] <= push_valid;
            last_sr[0]  <= push_last;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                last_sr[i]  <= last_sr[i-1];
            end
        end
    end

    assign tail_valid = valid_sr[DEPTH-1];
    assign tail_last  = last_sr[DEPTH-1];

endmodule

// File: rtl/rs_dsp_mac_accum.sv
// Operand sequencer and saturating product accumulator around an external
// DSP38 multiplier (20x18 -> 38, input and output registers).
module rs_dsp_mac_accum
    import rs_dsp_pkg::*;
#(
    parameter int ACC_W    = 48,
    parameter int CNT_W    = 8,
    parameter int MULT_LAT = 2
) (
    input  logic             clk,
    input  logic             lreset,
    rs_dsp_mac_accum_if.slave bus,
    output logic [A_W-1:0]   mult_a,
    output logic [B_W-1:0]   mult_b,
    output logic             mult_unsigned_a,
    output logic             mult_unsigned_b,
    output logic [2:0]       mult_feedback,
    input  logic [Z_W-1:0]   mult_z
);

    localparam int SHIFT = ACC_MAX - ACC_W;

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             sat;
    logic             ua_q;
    logic             ub_q;

    logic             accept;
    logic             first_beat;
    logic             tail_valid;
    logic             tail_last;
    logic             signed_mode;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] acc_next;
    sat_res_t         add_res;

    assign accept     = bus.in_valid & in_ready_q;
    assign first_beat = (state == IDLE);

    // Operands reach the multiplier only on accepted beats. Signedness
    // comes straight from the inputs on the first beat, then from the latch.
    assign mult_a          = accept ? bus.in_a : '0;
    assign mult_b          = accept ? bus.in_b : '0;
    assign mult_unsigned_a = first_beat ? bus.in_unsigned_a : ua_q;
    assign mult_unsigned_b = first_beat ? bus.in_unsigned_b : ub_q;
    assign mult_feedback   = 3'b000;

    rs_dsp_valid_pipe #(.DEPTH(MULT_LAT)) u_valid_pipe (
        .clk        (clk),
        .rst_n      (lreset),
        .push_valid (accept),
        .push_last  (accept & bus.in_last),
        .tail_valid (tail_valid),
        .tail_last  (tail_last)
    );

    // A mixed-sign product is still a signed number; only all-unsigned is not.
    assign signed_mode = !(ua_q && ub_q);
    assign addend      = signed_mode ? ACC_W'($signed(mult_z)) : ACC_W'(mult_z);
    assign add_res     = sat_add(ACC_MAX'(acc) << SHIFT,
                                 ACC_MAX'(addend) << SHIFT, signed_mode);
    assign acc_next    = add_res.sum[ACC_MAX-1 -: ACC_W];

    // Vector FSM with registered handshake outputs and the accumulator.
    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc         <= '0;
            count       <= '0;
            sat         <= 1'b0;
            ua_q        <= 1'b0;
            ub_q        <= 1'b0;
        end else begin
            if (tail_valid) begin
                acc <= acc_next;
                sat <= sat | add_res.overflow;
                if (count != '1) begin
                    count <= count + CNT_W'(1);
                end
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        ua_q       <= bus.in_unsigned_a;
                        ub_q       <= bus.in_unsigned_b;
                        state      <= bus.in_last ? DRAIN : ACCUM;
                        in_ready_q <= !bus.in_last;
                    end
                end
                ACCUM: begin
                    if (accept && bus.in_last) begin
                        state      <= DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (tail_valid && tail_last) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Result is released; clear for the next vector. in_ready
                    // rises only after this edge, so there is no bypass.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        acc         <= '0;
                        count       <= '0;
                        sat         <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc;
    assign bus.out_count = count;
    assign bus.out_sat   = sat;

endmodule

// File: tb/tb_rs_dsp_mac_accum.sv
// Bench for rs_dsp_mac_accum: two instances (48-bit and 40-bit accumulators)
// share one operand stream, each with its own multiplier model.
module tb_rs_dsp_mac_accum;
    import rs_dsp_pkg::*;

    typedef struct {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic           ua;
        logic           ub;
    } beat_t;

    logic clk;
    logic lreset;
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rs_dsp_mac_accum_if #(.ACC_W(48), .CNT_W(8)) bus48 ();
    rs_dsp_mac_accum_if #(.ACC_W(40), .CNT_W(8)) bus40 ();

    assign bus40.in_valid      = bus48.in_valid;
    assign bus40.in_a          = bus48.in_a;
    assign bus40.in_b          = bus48.in_b;
    assign bus40.in_last       = bus48.in_last;
    assign bus40.in_unsigned_a = bus48.in_unsigned_a;
    assign bus40.in_unsigned_b = bus48.in_unsigned_b;
    assign bus40.out_ready     = bus48.out_ready;

    logic [A_W-1:0] ma48, ma40, ra48, ra40;
    logic [B_W-1:0] mb48, mb40, rb48, rb40;
    logic           mua48, mub48, mua40, mub40;
    logic           rua48, rub48, rua40, rub40;
    logic [2:0]     fb48, fb40;
    logic [Z_W-1:0] z48, z40;

    function automatic longint op_val(input logic [31:0] raw, input int w, input logic uns);
        longint v;
        v = longint'(raw);
        if (!uns && raw[w-1]) v = v - (longint'(1) << w);
        return v;
    endfunction

    // Behavioural DSP38: registered inputs, registered 38-bit product.
    function automatic logic [Z_W-1:0] mult_model(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                                  input logic ua, input logic ub);
        return Z_W'(op_val(32'(a), A_W, ua) * op_val(32'(b), B_W, ub));
    endfunction

    always @(posedge clk) begin
        ra48 <= ma48; rb48 <= mb48; rua48 <= mua48; rub48 <= mub48;
        ra40 <= ma40; rb40 <= mb40; rua40 <= mua40; rub40 <= mub40;
        z48  <= mult_model(ra48, rb48, rua48, rub48);
        z40  <= mult_model(ra40, rb40, rua40, rub40);
    end

    rs_dsp_mac_accum #(.ACC_W(48), .CNT_W(8), .MULT_LAT(2)) dut48 (
        .clk(clk), .lreset(lreset), .bus(bus48),
        .mult_a(ma48), .mult_b(mb48), .mult_unsigned_a(mua48), .mult_unsigned_b(mub48),
        .mult_feedback(fb48), .mult_z(z48)
    );

    rs_dsp_mac_accum #(.ACC_W(40), .CNT_W(8), .MULT_LAT(2)) dut40 (
        .clk(clk), .lreset(lreset), .bus(bus40),
        .mult_a(ma40), .mult_b(mb40), .mult_unsigned_a(mua40), .mult_unsigned_b(mub40),
        .mult_feedback(fb40), .mult_z(z40)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: exact products, running sum clamped to the w-bit range of
    // the vector's mode (taken from its first beat).
    function automatic void model(input beat_t v[$], input int w, output logic [63:0] sum,
                                  output logic [63:0] cnt, output logic sat);
        logic   uns;
        longint acc, hi, lo;
        uns = v[0].ua && v[0].ub;
        acc = 0;
        sat = 1'b0;
        if (uns) begin
            lo = 0;
            hi = (longint'(1) << w) - 1;
        end else begin
            hi = (longint'(1) << (w - 1)) - 1;
            lo = -hi - 1;
        end
        foreach (v[i]) begin
            acc = acc + op_val(32'(v[i].a), A_W, v[0].ua) * op_val(32'(v[i].b), B_W, v[0].ub);
            if (acc > hi) begin acc = hi; sat = 1'b1; end
            else if (acc < lo) begin acc = lo; sat = 1'b1; end
        end
        sum = 64'(acc) & ((64'd1 << w) - 64'd1);
        cnt = (v.size() > 255) ? 64'd255 : 64'(v.size());
    endfunction

    task automatic send_vec(input beat_t v[$]);
        foreach (v[i]) begin
            if ($urandom_range(0, 3) == 0) begin
                bus48.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus48.in_valid      = 1'b1;
            bus48.in_a          = v[i].a;
            bus48.in_b          = v[i].b;
            bus48.in_unsigned_a = v[i].ua;
            bus48.in_unsigned_b = v[i].ub;
            bus48.in_last       = (i == v.size() - 1);
            #1;
            check("beat_in_ready", 64'(bus48.in_ready), 64'd1);
            check("beat_mult_a", 64'(ma48), 64'(v[i].a));
            @(posedge clk); #1;
        end
        bus48.in_valid = 1'b0;
        bus48.in_last  = 1'b0;
        bus48.in_a     = 20'($urandom);
        bus48.in_b     = 18'($urandom);
        #1;
        check("idle_mult_a", 64'(ma48), 64'd0);
        check("idle_mult_b", 64'(mb40), 64'd0);
    endtask

    // Counts edges after the last accepting edge until out_valid (bounded).
    task automatic wait_done(output logic ok);
        int lat;
        lat = 0;
        while (!bus48.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_latency", 64'(lat), 64'd2);
        ok = bus48.out_valid;
    endtask

    task automatic check_result(input beat_t v[$]);
        logic [63:0] s, c;
        logic        st;
        model(v, 48, s, c, st);
        check("sum48", 64'(bus48.out_sum), s);
        check("count48", 64'(bus48.out_count), c);
        check("sat48", 64'(bus48.out_sat), 64'(st));
        model(v, 40, s, c, st);
        check("sum40", 64'(bus40.out_sum), s);
        check("count40", 64'(bus40.out_count), c);
        check("sat40", 64'(bus40.out_sat), 64'(st));
        check("done_in_ready", 64'(bus48.in_ready), 64'd0);
    endtask

    task automatic handshake(input int hold);
        logic [63:0] held;
        held = 64'(bus48.out_sum);
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_sum", 64'(bus48.out_sum), held);
            check("hold_valid", 64'(bus48.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus48.in_ready), 64'd0);
        end
        bus48.out_ready = 1'b1;
        @(posedge clk); #1;
        bus48.out_ready = 1'b0;
        check("post_valid", 64'(bus48.out_valid), 64'd0);
        check("post_in_ready", 64'(bus48.in_ready), 64'd1);
        check("post_sum", 64'(bus48.out_sum), 64'd0);
        check("post_sat40", 64'(bus40.out_sat), 64'd0);
    endtask

    task automatic run_vec(input beat_t v[$], input int hold);
        logic ok;
        send_vec(v);
        wait_done(ok);
        if (ok) check_result(v);
        handshake(hold);
    endtask

    function automatic beat_t mk(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                 input logic ua, input logic ub);
        beat_t t;
        t.a = a; t.b = b; t.ua = ua; t.ub = ub;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t v[$];
        logic  ok;

        lreset              = 1'b0;
        bus48.in_valid      = 1'b0;
        bus48.in_a          = '0;
        bus48.in_b          = '0;
        bus48.in_last       = 1'b0;
        bus48.in_unsigned_a = 1'b0;
        bus48.in_unsigned_b = 1'b0;
        bus48.out_ready     = 1'b0;
        #22;
        check("rst_out_valid", 64'(bus48.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus48.in_ready), 64'd1);
        check("rst_sum", 64'(bus48.out_sum), 64'd0);
        check("rst_count", 64'(bus40.out_count), 64'd0);
        check("rst_sat", 64'(bus48.out_sat), 64'd0);
        check("rst_mult_a", 64'(ma48), 64'd0);
        check("feedback", 64'(fb48), 64'd0);
        @(negedge clk);
        lreset = 1'b1;
        @(posedge clk); #1;

        // Signed 3-term vector, gap-free, with 10 cycles of backpressure.
        v = {mk(20'd3, 18'd4, 0, 0), mk(-20'sd5, 18'd6, 0, 0), mk(20'd100, -18'sd2, 0, 0)};
        foreach (v[i]) begin
            bus48.in_valid = 1'b1; bus48.in_a = v[i].a; bus48.in_b = v[i].b;
            bus48.in_unsigned_a = 1'b0; bus48.in_unsigned_b = 1'b0;
            bus48.in_last = (i == 2);
            @(posedge clk); #1;
        end
        bus48.in_valid = 1'b0; bus48.in_last = 1'b0;
        wait_done(ok);
        check("signed_sum_const", 64'(bus48.out_sum), 64'hFFFF_FFFF_FF26);
        if (ok) check_result(v);
        handshake(10);

        // Unsigned single-term maximum product.
        v = {mk(20'hFFFFF, 18'h3FFFF, 1, 1)};
        send_vec(v);
        wait_done(ok);
        check("uns_single_const", 64'(bus48.out_sum), 64'h3F_FFEC_0001);
        if (ok) check_result(v);
        handshake(0);

        // Five max unsigned products saturate the 40-bit instance only.
        v = {};
        repeat (5) v.push_back(mk(20'hFFFFF, 18'h3FFFF, 1, 1));
        send_vec(v);
        wait_done(ok);
        check("sat40_sum_const", 64'(bus40.out_sum), 64'hFF_FFFF_FFFF);
        check("sat40_flag_const", 64'(bus40.out_sat), 64'd1);
        if (ok) check_result(v);
        handshake(2);

        // Unsigned mode latched on beat 1; the later in_unsigned_a=0 is ignored.
        v = {mk(20'd2, 18'd3, 1, 1), mk(20'hFFFFF, 18'd2, 0, 1)};
        send_vec(v);
        wait_done(ok);
        check("mode_latch_const", 64'(bus48.out_sum), 64'd2097156);
        if (ok) check_result(v);
        handshake(1);

        // Reset while products are in flight; stale products must be ignored.
        bus48.in_valid = 1'b1; bus48.in_a = 20'd7; bus48.in_b = 18'd9;
        bus48.in_unsigned_a = 1'b0; bus48.in_unsigned_b = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        lreset = 1'b0;
        #1;
        check("midrst_in_ready", 64'(bus48.in_ready), 64'd1);
        check("midrst_count", 64'(bus48.out_count), 64'd0);
        bus48.in_valid = 1'b0;
        @(negedge clk);
        lreset = 1'b1;
        @(posedge clk); #1;
        v = {mk(20'd11, 18'd13, 0, 0), mk(20'd5, 18'd1, 0, 0)};
        run_vec(v, 0);

        // Reset while holding a result in DONE clears it without a clock edge.
        v = {mk(20'd1000, 18'd1000, 1, 1), mk(20'd3, 18'd3, 1, 1)};
        send_vec(v);
        wait_done(ok);
        check("done_before_rst", 64'(bus48.out_valid), 64'd1);
        #2;
        lreset = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus48.out_valid), 64'd0);
        check("async_rst_sum", 64'(bus48.out_sum), 64'd0);
        check("async_rst_count", 64'(bus48.out_count), 64'd0);
        check("async_rst_in_ready", 64'(bus48.in_ready), 64'd1);
        @(negedge clk);
        lreset = 1'b1;
        @(posedge clk); #1;

        // Randomised vectors: lengths, modes, operands, bubbles, backpressure.
        for (int n = 0; n < 12; n++) begin
            logic ua, ub;
            int   len;
            v   = {};
            len = $urandom_range(1, 6);
            ua  = 1'($urandom_range(0, 1));
            ub  = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++)
                v.push_back(mk(20'($urandom), 18'($urandom), ua, ub));
            run_vec(v, $urandom_range(0, 3));
        end

        // Long vector: term count saturates at all-ones.
        v = {};
        for (int i = 0; i < 300; i++)
            v.push_back(mk(20'($urandom_range(0, 255)), 18'($urandom_range(0, 255)), 1, 1));
        run_vec(v, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_dsp_mac_accum.md
# rs_dsp_mac_accum

Operand sequencer and product accumulator wrapped around a DSP38 multiplier configured for MULTIPLY with input and output registers (20x18 -> 38-bit, 2-cycle latency). It accepts a stream of operand pairs with a last-flag and drives the multiplier's inputs. It tracks in-flight products, accumulates the products into a wide saturating sum, and presents one result per vector on a ready/valid output. The multiplier is instantiated alongside this block, not inside it.

## Interface
- ACC_W, 48, accumulator and out_sum width; must be >= 38
- CNT_W, 8, term-counter width
- MULT_LAT, 2, multiplier latency in clk cycles (input reg + output reg)
- clk  in  1  single clock; rising edge
- lreset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block accepts pair this cycle
- in_a  in  20  multiplicand
- in_b  in  18  multiplier
- in_last  in  1  final pair of the vector
- in_unsigned_a / in_unsigned_b  in  1 each  operand signedness; sampled on the first beat of a vector only
- mult_a / mult_b  out  20 / 18  to the multiplier's A/B ports
- mult_unsigned_a / mult_unsigned_b  out  1 each  to the multiplier's UNSIGNED_A/B ports
- mult_feedback  out  3  tied to 3'b000
- mult_z  in  38  product from the multiplier
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_sum  out  ACC_W  accumulated sum
- out_count  out  CNT_W  number of terms, saturating at all-ones
- out_sat  out  1  sum clamped at least once in this vector

## Operation
- Accept: a pair is accepted when in_valid && in_ready. mult_a/mult_b are driven combinationally from in_a/in_b whenever a pair is accepted, and are 0 otherwise.
- Mode latch: the signedness mode is captured on the first accepted beat of a vector. The product is signed unless both unsigned flags are 1. Flag changes later in the same vector are ignored.
- Flag pipeline: a MULT_LAT-deep shift register carries {valid, last} alongside the multiplier.
- Product extension: when the pipeline tail is valid, mult_z is sign- or zero-extended to ACC_W and added to acc.
- Signed saturation: on overflow, acc clamps to the signed max or min of ACC_W bits. out_sat is sticky and is set.
- Unsigned saturation: on carry-out, acc clamps to all-ones. out_sat is set.
- State IDLE: acc=0, count=0, sat=0, in_ready=1. An accept moves the FSM to ACCUM, or to DRAIN if in_last is set on that beat.
- State ACCUM: in_ready=1. An accept with in_last moves the FSM to DRAIN.
- State DRAIN: in_ready=0. When the tail entry carrying last is accumulated, the FSM moves to DONE.
- State DONE: out_valid=1 and in_ready=0. out_sum, out_count and out_sat hold stable. out_ready moves the FSM to IDLE.
- Single-beat vectors are legal: first beat and last beat are the same beat.
- No bypass: a new vector cannot be accepted in the same cycle as the DONE handshake.
- Reset values: in_ready=1 and FSM in IDLE. out_valid=0, out_sum=0, out_count=0, out_sat=0; mult_a and mult_b are 0; the flag pipeline is cleared.
- Reset mid-operation takes effect asynchronously. Any product arriving after reset release is ignored because its pipeline flag was cleared.

## Timing
- A pair accepted at cycle t yields a product on mult_z at cycle t+MULT_LAT, added at the edge ending that cycle.
- If the last pair is accepted at cycle t, out_valid rises at cycle t+MULT_LAT+1.
- Back-to-back accepts are allowed every cycle in ACCUM, giving throughput of 1 pair/cycle.
- The gap between vectors is at least MULT_LAT+2 cycles, including the DONE handshake cycle.
- The multiplier's own reset is not driven by this block.

## Structure
- Package rs_dsp_pkg:
  - widths A_W=20, B_W=18, Z_W=38
  - state enum {IDLE, ACCUM, DRAIN, DONE}
  - function sat_add(acc, addend, signed_mode) returning {sum, overflow}
- Sub-module rs_dsp_valid_pipe: parameterised MULT_LAT-deep {valid, last} shift register with asynchronous active-low clear.

## Test plan
- Reset: assert lreset=0 mid-stream. Expect out_valid=0, in_ready=1, out_sum=0 and out_count=0 immediately, with no clk edge needed.
- Signed 3-term vector (3,4), (-5,6), (100,-2) on consecutive cycles, last on beat 3 at cycle t. Expect out_sum=-218, out_count=3, out_sat=0, out_valid at t+3.
- Unsigned single term: a=20'hFFFFF, b=18'h3FFFF, both unsigned, last on beat 1. Expect out_sum=38'h3F_FFEC_0001 and out_count=1.
- Saturation with ACC_W=40: unsigned, 5 terms of max product. Expect out_sum=40'hFF_FFFF_FFFF and out_sat=1; the next vector starts with out_sat=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Expect out_sum stable and in_ready=0; after the handshake, expect IDLE with in_ready=1 on the next cycle.
- Mode latch: toggle in_unsigned_a mid-vector. Expect the result computed with the first-beat mode.
